// File: rtl/ahb_arb_pkg.sv
// Shared AHB transfer encodings and the rotating-priority search used by the bus arbiters.
package ahb_arb_pkg;

  typedef logic [1:0] htrans_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  localparam int unsigned MAX_MASTERS = 8;

  // First set index at or above ptr, wrapping at n; returns ptr when nothing is set.
  function automatic logic [2:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                         input logic [2:0] ptr, input int unsigned n);
    logic [2:0]  res;
    logic        found;
    int unsigned j;
    res   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      j = (32'(ptr) + k) % n;
      if (!found && (k < n) && req[j[2:0]]) begin
        res   = j[2:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority.sv
// Combinational rotating-priority encoder: highest priority at ptr, descending with wrap.
module rr_priority
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic [2:0]             sel;

  assign req_ext = MAX_MASTERS'(req);
  assign sel     = rr_next(req_ext, 3'(ptr), NUM_MASTERS);
  assign any     = |req;
  assign idx     = IDX_W'(sel);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt[i] = any && (sel == 3'(i));
    end
  end

endmodule

// File: rtl/ahb_multi_arbiter.sv
// N-master AHB-Lite arbiter: combinational address-phase mux, registered data-phase owner,
// round-robin fairness and HMASTLOCK-held ownership.
module ahb_multi_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_HADDR,
  input  logic [NUM_MASTERS*2-1:0]      M_HTRANS,
  input  logic [NUM_MASTERS-1:0]        M_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]      M_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]      M_HBURST,
  input  logic [NUM_MASTERS*4-1:0]      M_HPROT,
  input  logic [NUM_MASTERS-1:0]        M_HMASTLOCK,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_HWDATA,
  input  logic [NUM_MASTERS*STRB_W-1:0] M_HWSTRB,
  output logic [NUM_MASTERS-1:0]        M_HREADY,
  output logic [DATA_W-1:0]             M_HRDATA,
  output logic [NUM_MASTERS-1:0]        M_HRESP,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [3:0]                    HPROT,
  output logic                          HMASTLOCK,
  output logic [DATA_W-1:0]             HWDATA,
  output logic [STRB_W-1:0]             HWSTRB,
  input  logic                          HREADY,
  input  logic                          HRESP,
  input  logic [DATA_W-1:0]             HRDATA,
  output logic [IDX_W-1:0]              GrantIdx
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_MASTERS - 1);

  logic [ADDR_W-1:0] haddr_m  [NUM_MASTERS];
  htrans_t           htrans_m [NUM_MASTERS];
  logic [2:0]        hsize_m  [NUM_MASTERS];
  logic [2:0]        hburst_m [NUM_MASTERS];
  logic [3:0]        hprot_m  [NUM_MASTERS];
  logic [DATA_W-1:0] hwdata_m [NUM_MASTERS];
  logic [STRB_W-1:0] hwstrb_m [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] req;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign haddr_m[i]  = M_HADDR[i*ADDR_W +: ADDR_W];
    assign htrans_m[i] = M_HTRANS[i*2 +: 2];
    assign hsize_m[i]  = M_HSIZE[i*3 +: 3];
    assign hburst_m[i] = M_HBURST[i*3 +: 3];
    assign hprot_m[i]  = M_HPROT[i*4 +: 4];
    assign hwdata_m[i] = M_HWDATA[i*DATA_W +: DATA_W];
    assign hwstrb_m[i] = M_HWSTRB[i*STRB_W +: STRB_W];
    assign req[i]      = M_HTRANS[i*2+1];
  end

  logic             data_active_q, data_active_d;
  logic [IDX_W-1:0] data_owner_q, data_owner_d;
  logic             lock_active_q, lock_active_d;
  logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_MASTERS-1:0] rr_gnt;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_any;
  logic [IDX_W-1:0]       grant;
  htrans_t                htrans_sel;
  logic                   lock_sel;

  rr_priority #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_priority (
    .req(req),
    .ptr(rr_ptr_q),
    .gnt(rr_gnt),
    .idx(rr_idx),
    .any(rr_any)
  );

  // Lock owner first, then a data-phase owner continuing its run, then round-robin.
  always_comb begin
    grant = (rr_ptr_q == '0) ? LastIdx : rr_ptr_q - IDX_W'(1);
    if (reset) begin
      grant = LastIdx;
    end else if (lock_active_q) begin
      grant = lock_owner_q;
    end else if (data_active_q && req[data_owner_q]) begin
      grant = data_owner_q;
    end else if (rr_any) begin
      grant = rr_idx;
    end
  end

  assign htrans_sel = (!reset && req[grant]) ? htrans_m[grant] : HTRANS_IDLE;
  assign lock_sel   = !reset && M_HMASTLOCK[grant];

  assign HADDR     = haddr_m[grant];
  assign HTRANS    = htrans_sel;
  assign HWRITE    = M_HWRITE[grant];
  assign HSIZE     = hsize_m[grant];
  assign HBURST    = hburst_m[grant];
  assign HPROT     = hprot_m[grant];
  assign HMASTLOCK = lock_sel;
  assign HWDATA    = hwdata_m[data_owner_q];
  assign HWSTRB    = hwstrb_m[data_owner_q];
  assign M_HRDATA  = HRDATA;
  assign GrantIdx  = grant;

  // Requesters that are neither granted nor in data phase stall with their address held.
  always_comb begin
    M_HREADY = '0;
    M_HRESP  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (reset) begin
        M_HREADY[i] = 1'b1;
      end else if ((grant == IDX_W'(i)) || (data_active_q && (data_owner_q == IDX_W'(i)))
                   || !req[i]) begin
        M_HREADY[i] = HREADY;
      end
      M_HRESP[i] = !reset && HRESP && data_active_q && (data_owner_q == IDX_W'(i));
    end
  end

  always_comb begin
    data_active_d = data_active_q;
    data_owner_d  = data_owner_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    rr_ptr_d      = rr_ptr_q;
    if (HREADY) begin
      if (htrans_sel != HTRANS_IDLE) begin
        data_active_d = 1'b1;
        data_owner_d  = grant;
        rr_ptr_d      = (grant == LastIdx) ? '0 : grant + IDX_W'(1);
        if (lock_sel) begin
          lock_active_d = 1'b1;
          lock_owner_d  = grant;
        end
      end else begin
        data_active_d = 1'b0;
      end
      if (!lock_sel) begin
        lock_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_active_q <= 1'b0;
      data_owner_q  <= '0;
      lock_active_q <= 1'b0;
      lock_owner_q  <= '0;
      rr_ptr_q      <= '0;
    end else begin
      data_active_q <= data_active_d;
      data_owner_q  <= data_owner_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rr_any) begin
      assert (rr_gnt[rr_idx]);
    end
  end

endmodule

// File: doc/ahb_multi_arbiter.md
Name: ahb_multi_arbiter

Overview:
- N-master AHB-Lite arbiter that lets several bus masters share one uncore/external AHB slave port.
- Typical masters: multiple harts' EBUs, or a hart plus a DMA/debug master.
- Sits between the masters' AHB ports and the uncore.
- Provides round-robin address-phase arbitration, data-phase routing and HMASTLOCK-held ownership.

Parameters:
- NUM_MASTERS, 2, number of masters (2..8).
- ADDR_W, 32, HADDR width (PA_BITS in system use).
- DATA_W, 64, HWDATA/HRDATA width (AHBW); strobe width is DATA_W/8.
- IDX_W, $clog2(NUM_MASTERS), master index width (derived, not overridable).

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- M_HADDR  in  NUM_MASTERS*ADDR_W  per-master address, master i at slice i
- M_HTRANS  in  NUM_MASTERS*2  per-master transfer type
- M_HWRITE  in  NUM_MASTERS  per-master write
- M_HSIZE  in  NUM_MASTERS*3  per-master size
- M_HBURST  in  NUM_MASTERS*3  per-master burst
- M_HPROT  in  NUM_MASTERS*4  per-master protection
- M_HMASTLOCK  in  NUM_MASTERS  per-master lock
- M_HWDATA  in  NUM_MASTERS*DATA_W  per-master write data
- M_HWSTRB  in  NUM_MASTERS*DATA_W/8  per-master strobes
- M_HREADY  out  NUM_MASTERS  per-master ready
- M_HRDATA  out  DATA_W  read data, broadcast to all masters
- M_HRESP  out  NUM_MASTERS  per-master response
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK  out  ADDR_W/2/1/3/3/4/1  slave address phase
- HWDATA  out  DATA_W  slave write data
- HWSTRB  out  DATA_W/8  slave strobes
- HREADY  in  1  slave ready
- HRESP  in  1  slave response
- HRDATA  in  DATA_W  slave read data
- GrantIdx  out  IDX_W  current address-phase owner (debug/perf)

Behaviour:
- Request: req[i] = M_HTRANS[i][1] (NONSEQ or SEQ).
- Registers:
  - DataActive, DataOwner: master whose transfer is in data phase.
  - LockOwner, LockActive: HMASTLOCK ownership.
  - RRPtr: index just above last granted master.
- Address-owner selection, combinational, evaluated every cycle, first match wins:
  1. LockActive -> LockOwner.
  2. DataActive and req[DataOwner] -> DataOwner. This keeps bursts and back-to-back transfers contiguous and guarantees a data-phase owner is never denied its next address.
  3. Otherwise round-robin over req starting at RRPtr.
  4. No request -> GrantIdx = RRPtr-1 (mod N) with HTRANS forced to IDLE.
- Slave address outputs are muxed from GrantIdx. HTRANS = M_HTRANS[GrantIdx] if req[GrantIdx], else 2'b00.
- Accept: HREADY=1 and HTRANS!=IDLE. On accept:
  - DataActive<=1, DataOwner<=GrantIdx.
  - RRPtr<=(GrantIdx+1) mod NUM_MASTERS.
- HREADY=1 with HTRANS=IDLE -> DataActive<=0.
- HREADY=0 -> DataActive, DataOwner and RRPtr hold.
- Lock: on accept with M_HMASTLOCK[GrantIdx]=1 -> LockActive<=1, LockOwner<=GrantIdx. Cleared on an accepted cycle where the owner drives HMASTLOCK=0, or on an IDLE-accepted cycle with lock low.
- M_HREADY[i]:
  - = HREADY if i==GrantIdx, or (DataActive and i==DataOwner), or !req[i].
  - else 0: a non-granted requester stalls holding its address, per AHB rules.
- Data routing:
  - HWDATA/HWSTRB = master DataOwner's values.
  - M_HRDATA = HRDATA, broadcast.
  - M_HRESP[i] = HRESP & DataActive & (DataOwner==i).
- Two-cycle ERROR response is passed through unchanged. The owner sees both cycles. Arbitration continues per the rules above.
- Zero added latency: address phase is combinational pass-through.
- Reset (sync, overrides all):
  - DataActive=0, DataOwner=0, LockActive=0, RRPtr=0.
  - While reset=1: HTRANS=IDLE, HMASTLOCK=0, M_HREADY all 1, M_HRESP all 0, GrantIdx=NUM_MASTERS-1.
  - A transfer in flight at reset is abandoned; no response is routed.
- NUM_MASTERS=1 degenerates to pass-through; IDX_W is forced to min 1.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams.
  - htrans_t typedef.
  - Function rr_next(req, ptr) returning the first-set index at or above ptr, with wrap.
- One sub-module: rr_priority.
  - Combinational rotating-priority encoder: req vector + ptr -> onehot grant + index + any.
  - Parametrised by NUM_MASTERS; reused by future PLIC/DMA arbiters.

Test Plan:
- N=2, both masters issue NONSEQ reads at 0x1000 (M0) and 0x2000 (M1) in the same cycle after reset -> M0 granted (RRPtr=0), HADDR=0x1000. Next cycle HADDR=0x2000 with GrantIdx=1; HRDATA 0xA then 0xB reach M0 then M1 in order.
- M0 INCR4 burst (NONSEQ+3×SEQ) with M1 requesting throughout -> four consecutive M0 address phases, M1 M_HREADY=0 for four cycles, M1 granted on the fifth.
- Slave inserts 3 wait states (HREADY=0) during M1 write 0xDEADBEEF -> HWDATA stays M1's value, all address outputs stable, RRPtr unchanged.
- M1 asserts HMASTLOCK for read-modify-write while M0 requests -> M1 keeps grant for both transfers; M0 granted only after lock is dropped.
- ERROR response on M0 transfer -> M_HRESP[0]=1 for two cycles, M_HRESP[1]=0.
- N=4, reset asserted mid-burst of M2 -> next cycle HTRANS=IDLE and all M_HREADY=1. After release, simultaneous requests from M1 and M3 -> M1 granted first.
